// File: rtl/bcd_entry_ctrl_pkg.sv
// Shared calculator definitions: key codes, entry FSM states and the signed-BCD operand layout.
// Every calculator block imports this package.
package calc_pkg;

  localparam logic [3:0] KEY_SIGN = 4'hA;
  localparam logic [3:0] KEY_BKSP = 4'hB;
  localparam logic [3:0] KEY_CLR  = 4'hC;
  localparam logic [3:0] KEY_ENT  = 4'hE;

  localparam int MAG_LIMIT  = 127;
  localparam int NUM_DIGITS = 3;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    ENTRY     = 2'd1,
    COMMITTED = 2'd2
  } entry_state_t;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    logic       sign;
    bcd_digit_t h;
    bcd_digit_t t;
    bcd_digit_t u;
  } sbcd_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_entry_ctrl_if.sv
// Keypad-to-entry-stage bundle: key events in, live display and committed operand out.
interface bcd_entry_ctrl_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [12:0] disp_bcd;
  logic [1:0]  disp_count;
  logic [12:0] num_out;
  logic        num_valid;
  logic        key_reject;
  logic [1:0]  entry_state;

  modport master (
    output key_valid, key_code,
    input  disp_bcd, disp_count, num_out, num_valid, key_reject, entry_state
  );

  modport slave (
    input  key_valid, key_code,
    output disp_bcd, disp_count, num_out, num_valid, key_reject, entry_state
  );
endinterface

// File: rtl/bcd_entry_ctrl_mag_check.sv
// Decides whether appending digit d to the h/t/u entry stays within the digit and magnitude limits.
module bcd_mag_check
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = NUM_DIGITS,
  parameter int MAX_MAG    = MAG_LIMIT
) (
  input  bcd_digit_t h,
  input  bcd_digit_t t,
  input  bcd_digit_t u,
  input  bcd_digit_t d,
  input  logic [1:0] count,
  output logic       accept
);
  logic [10:0] cur, cand;

  // Live entry never exceeds MAX_MAG, so 11 bits hold cur*10+9 without wrap.
  always_comb begin
    cur    = 11'(h) * 11'd100 + 11'(t) * 11'd10 + 11'(u);
    cand   = cur * 11'd10 + 11'(d);
    accept = ({30'd0, count} < 32'(MAX_DIGITS)) && ({21'd0, cand} <= 32'(MAX_MAG));
  end
endmodule

// File: rtl/bcd_entry_ctrl.sv
// Keypad operand entry: builds a signed 3-digit BCD value from key events and commits it on ENTER.
module bcd_entry_ctrl
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = NUM_DIGITS,
  parameter int MAX_MAG    = MAG_LIMIT
) (
  input  logic           clk,
  input  logic           rst_n,
  bcd_entry_ctrl_if.slave kp
);
  entry_state_t state;
  sbcd_t        live, num_q;
  logic [1:0]   cnt;
  logic         nv_q, rej_q, accept;
  bcd_digit_t   d;
  logic         live_zero;

  assign d         = kp.key_code;
  assign live_zero = (live.h == 4'd0) && (live.t == 4'd0) && (live.u == 4'd0);

  bcd_mag_check #(
    .MAX_DIGITS(MAX_DIGITS),
    .MAX_MAG   (MAX_MAG)
  ) u_mag (
    .h     (live.h),
    .t     (live.t),
    .u     (live.u),
    .d     (d),
    .count (cnt),
    .accept(accept)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      live  <= '0;
      cnt   <= 2'd0;
      num_q <= '0;
      nv_q  <= 1'b0;
      rej_q <= 1'b0;
    end else begin
      nv_q  <= 1'b0;
      rej_q <= 1'b0;
      if (!(state inside {EMPTY, ENTRY, COMMITTED})) begin
        state <= EMPTY;
        live  <= '0;
        cnt   <= 2'd0;
      end else if (kp.key_valid) begin
        if (is_digit(kp.key_code)) begin
          if (state == COMMITTED) begin
            // A digit after a commit starts a fresh positive entry immediately.
            live  <= {1'b0, 4'd0, 4'd0, d};
            cnt   <= {1'b0, d != 4'd0};
            state <= (d != 4'd0) ? ENTRY : EMPTY;
          end else if (!accept) begin
            rej_q <= 1'b1;
          end else if (d != 4'd0 || cnt != 2'd0) begin
            live.h <= live.t;
            live.t <= live.u;
            live.u <= d;
            cnt    <= cnt + 2'd1;
            state  <= ENTRY;
          end
        end else begin
          case (kp.key_code)
            KEY_SIGN: begin
              if (state == COMMITTED) begin
                live  <= {1'b1, 12'd0};
                cnt   <= 2'd0;
                state <= EMPTY;
              end else begin
                live.sign <= ~live.sign;
              end
            end
            KEY_BKSP: begin
              if (state == ENTRY) begin
                live.u <= live.t;
                live.t <= live.h;
                live.h <= 4'd0;
                cnt    <= cnt - 2'd1;
                if (cnt == 2'd1) state <= EMPTY;
              end else begin
                rej_q <= 1'b1;
              end
            end
            KEY_CLR: begin
              live  <= '0;
              cnt   <= 2'd0;
              state <= EMPTY;
            end
            KEY_ENT: begin
              if (state != COMMITTED) begin
                // Zero magnitude commits as +0 regardless of the sign toggle.
                num_q <= {live.sign & ~live_zero, live.h, live.t, live.u};
                state <= COMMITTED;
              end
              nv_q <= 1'b1;
            end
            default: rej_q <= 1'b1;
          endcase
        end
      end
    end
  end

  assign kp.disp_bcd    = (state == COMMITTED) ? num_q : live;
  assign kp.disp_count  = cnt;
  assign kp.num_out     = num_q;
  assign kp.num_valid   = nv_q;
  assign kp.key_reject  = rej_q;
  assign kp.entry_state = state;
endmodule

// File: tb/tb_bcd_entry_ctrl.sv
// Bench for bcd_entry_ctrl: directed key scenarios plus random key streams against an integer-valued model.
module tb_bcd_entry_ctrl;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_entry_ctrl_if kp();

  bcd_entry_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .kp   (kp)
  );

  int errors = 0;
  int checks = 0;

  // Model keeps the entry as a plain integer magnitude plus sign.
  int          m_sign, m_mag, m_cnt, m_state;
  logic [12:0] m_num;
  logic        m_nv, m_rej;

  function automatic logic [12:0] pk(input int s, input int m);
    return {s[0], 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic logic [29:0] expv();
    return {(m_state == 2) ? m_num : pk(m_sign, m_mag), m_num, m_nv, m_rej, 2'(m_state)};
  endfunction

  function automatic logic [29:0] obs();
    return {kp.disp_bcd, kp.num_out, kp.num_valid, kp.key_reject, kp.entry_state};
  endfunction

  task automatic model_reset();
    m_sign = 0; m_mag = 0; m_cnt = 0; m_state = 0;
    m_num = '0; m_nv = 1'b0; m_rej = 1'b0;
  endtask

  task automatic model_key(input logic v, input logic [3:0] c);
    m_nv = 1'b0;
    m_rej = 1'b0;
    if (v) begin
      if (c <= 4'd9) begin
        if (m_state == 2) begin
          m_sign = 0; m_mag = int'(c); m_cnt = (c != 0) ? 1 : 0; m_state = (c != 0) ? 1 : 0;
        end else if (m_cnt >= 3 || m_mag * 10 + int'(c) > 127) begin
          m_rej = 1'b1;
        end else if (!(c == 0 && m_cnt == 0)) begin
          m_mag = m_mag * 10 + int'(c); m_cnt++; m_state = 1;
        end
      end else begin
        case (c)
          4'hA: if (m_state == 2) begin
                  m_sign = 1; m_mag = 0; m_cnt = 0; m_state = 0;
                end else m_sign = 1 - m_sign;
          4'hB: if (m_state == 1) begin
                  m_mag = m_mag / 10; m_cnt--; if (m_cnt == 0) m_state = 0;
                end else m_rej = 1'b1;
          4'hC: begin m_sign = 0; m_mag = 0; m_cnt = 0; m_state = 0; end
          4'hE: begin
                  if (m_state != 2) begin
                    m_num = pk((m_mag == 0) ? 0 : m_sign, m_mag); m_state = 2;
                  end
                  m_nv = 1'b1;
                end
          default: m_rej = 1'b1;
        endcase
      end
    end
  endtask

  // Called at a falling edge: drive, let one rising edge sample, return at the next falling edge.
  task automatic apply(input logic v, input logic [3:0] c);
    kp.key_valid = v;
    kp.key_code  = c;
    @(negedge clk);
    model_key(v, c);
  endtask

  task automatic test_reset();
    model_reset();
    if (obs() !== 30'd0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", obs());
    end
    checks++;
    if (kp.disp_count !== 2'd0) begin
      errors++; $display("FAIL reset_count got %0d exp 0", kp.disp_count);
    end
    checks++;
  endtask

  task automatic test_enter_127();
    logic [3:0] seq[$] = '{4'h1, 4'h2, 4'h7, 4'hE, 4'h0};
    foreach (seq[i]) begin
      apply(i < 4, seq[i]);
      if (obs() !== expv()) begin
        errors++; $display("FAIL enter127 step %0d got %h exp %h", i, obs(), expv());
      end
      checks++;
      if (i == 2 && kp.disp_bcd !== 13'h0127) begin
        errors++; $display("FAIL enter127_disp got %h exp 0127", kp.disp_bcd);
      end
      if (i == 2) checks++;
      if (i == 3 && {kp.num_out, kp.num_valid, kp.entry_state} !== {13'h0127, 1'b1, 2'd2}) begin
        errors++; $display("FAIL enter127_commit got %h/%b/%0d", kp.num_out, kp.num_valid, kp.entry_state);
      end
      if (i == 3) checks++;
    end
  endtask

  task automatic test_range();
    logic [3:0] seq[$] = '{4'hC, 4'h1, 4'h2, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
    foreach (seq[i]) begin
      apply(1'b1, seq[i]);
      if (obs() !== expv() || kp.disp_count !== 2'(m_cnt)) begin
        errors++; $display("FAIL range step %0d got %h/%0d exp %h/%0d", i, obs(), kp.disp_count, expv(), m_cnt);
      end
      checks++;
      if (i == 3 && {kp.disp_bcd, kp.key_reject} !== {13'h0012, 1'b1}) begin
        errors++; $display("FAIL range_128 got %h rej %b exp 0012 rej 1", kp.disp_bcd, kp.key_reject);
      end
      if (i == 3) checks++;
    end
    apply(1'b0, 4'h0);
    if (kp.key_reject !== 1'b0) begin
      errors++; $display("FAIL range_pulse got %b exp 0", kp.key_reject);
    end
    checks++;
  endtask

  task automatic test_sign();
    logic [3:0] seq[$] = '{4'hC, 4'hA, 4'h4, 4'h5, 4'hE, 4'h3};
    foreach (seq[i]) begin
      apply(1'b1, seq[i]);
      if (obs() !== expv()) begin
        errors++; $display("FAIL sign step %0d got %h exp %h", i, obs(), expv());
      end
      checks++;
    end
    if ({kp.disp_bcd, kp.num_out} !== {13'h0003, 13'h1045}) begin
      errors++; $display("FAIL sign_newentry got %h/%h exp 0003/1045", kp.disp_bcd, kp.num_out);
    end
    checks++;
  endtask

  task automatic test_negzero_bksp();
    logic [3:0] seq[$] = '{4'hC, 4'hA, 4'h0, 4'hE, 4'h9, 4'hB, 4'hB};
    foreach (seq[i]) begin
      apply(1'b1, seq[i]);
      if (obs() !== expv()) begin
        errors++; $display("FAIL negzero step %0d got %h exp %h", i, obs(), expv());
      end
      checks++;
      if (i == 3 && kp.num_out !== 13'h0000) begin
        errors++; $display("FAIL negzero_commit got %h exp 0000", kp.num_out);
      end
      if (i == 3) checks++;
    end
    if ({kp.entry_state, kp.disp_count, kp.key_reject} !== {2'd0, 2'd0, 1'b1}) begin
      errors++; $display("FAIL bksp_empty got st %0d cnt %0d rej %b", kp.entry_state, kp.disp_count, kp.key_reject);
    end
    checks++;
  endtask

  task automatic test_async_reset();
    logic [3:0] seq[$] = '{4'h4, 4'h2, 4'hE, 4'h6, 4'h7};
    foreach (seq[i]) apply(1'b1, seq[i]);
    apply(1'b0, 4'h0);
    if (obs() !== expv()) begin
      errors++; $display("FAIL arst_pre got %h exp %h", obs(), expv());
    end
    checks++;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    if (obs() !== 30'd0 || kp.disp_count !== 2'd0) begin
      errors++; $display("FAIL arst_immediate got %h cnt %0d exp 0", obs(), kp.disp_count);
    end
    checks++;
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, 4'hE);
    if ({kp.num_out, kp.num_valid} !== {13'h0000, 1'b1} || obs() !== expv()) begin
      errors++; $display("FAIL arst_enter got %h exp %h", obs(), expv());
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq[$] = '{4'hC, 4'h5, 4'h5, 4'h5, 4'hD, 4'hF};
    foreach (seq[i]) begin
      apply(1'b1, seq[i]);
      if (obs() !== expv()) begin
        errors++; $display("FAIL b2b step %0d got %h exp %h", i, obs(), expv());
      end
      checks++;
      if (i >= 3 && {kp.disp_bcd, kp.key_reject} !== {13'h0055, 1'b1}) begin
        errors++; $display("FAIL b2b_reject step %0d got %h rej %b", i, kp.disp_bcd, kp.key_reject);
      end
      if (i >= 3) checks++;
    end
    apply(1'b0, 4'h0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      apply($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)));
      if (obs() !== expv()) begin
        errors++; $display("FAIL random step %0d got %h exp %h", n, obs(), expv());
      end
      checks++;
      if (m_state != 2 && kp.disp_count !== 2'(m_cnt)) begin
        errors++; $display("FAIL random_count step %0d got %0d exp %0d", n, kp.disp_count, m_cnt);
      end
      if (m_state != 2) checks++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    kp.key_valid = 1'b0;
    kp.key_code  = 4'h0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_enter_127();
    test_range();
    test_sign();
    test_negzero_bksp();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
